// File: rtl/rmii_mdio_ctrl.sv
// Clause-22 MDIO management master: one read/write request at a time, serialised on MDC/MDIO.
// Optional preamble suppression (req_nopre port) is built when RMII_MDIO_PRE_SUPPRESS_EN is defined.
module rmii_mdio_ctrl #(
  parameter int CLK_DIV = 10
) (
  input  logic        clk_rmii,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_mdc,
  output logic        o_mdio,
  output logic        oe_mdio,
  input  logic        i_mdio
`ifdef RMII_MDIO_PRE_SUPPRESS_EN
  ,
  input  logic        req_nopre
`endif
);

  // Request handshake: a request is taken in any cycle where req_valid & req_ready;
  // req_ready is registered and only high while the engine sits in IDLE.

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CMD,
    S_TA,
    S_DATA,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic        write_q, write_d;
  logic [13:0] cmd_q, cmd_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] sr_q, sr_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ready_q, ready_d;
  logic        sync1_q, sync2_q;
  logic        nopre;
  logic        handshake, div_last, rise, bit_end, load_drive;
  logic [1:0]  drive_d;

`ifdef RMII_MDIO_PRE_SUPPRESS_EN
  assign nopre = req_nopre;
`else
  assign nopre = 1'b0;
`endif

  function automatic logic [5:0] last_bit(input state_t s);
    case (s)
      S_PRE:   last_bit = 6'd31;
      S_CMD:   last_bit = 6'd13;
      S_TA:    last_bit = 6'd1;
      S_DATA:  last_bit = 6'd15;
      default: last_bit = 6'd0;
    endcase
  endfunction

  // Returns {oe, value} for the bit about to start; released bits idle high.
  function automatic logic [1:0] drive_bit(input state_t s, input logic [5:0] idx,
                                           input logic wr, input logic [13:0] cmd,
                                           input logic [15:0] wd);
    logic [3:0] ci;
    logic [3:0] di;
    ci = 4'd13 - idx[3:0];
    di = 4'd15 - idx[3:0];
    case (s)
      S_PRE:   drive_bit = 2'b11;
      S_CMD:   drive_bit = {1'b1, cmd[ci]};
      S_TA:    drive_bit = wr ? {1'b1, (idx == 6'd0)} : 2'b01;
      S_DATA:  drive_bit = wr ? {1'b1, wd[di]} : 2'b01;
      default: drive_bit = 2'b01;
    endcase
  endfunction

  assign handshake = req_valid & ready_q;
  assign div_last  = (div_q == DIV_LAST);
  assign rise      = (state_q != S_IDLE) && !mdc_q && div_last;
  assign bit_end   = (state_q != S_IDLE) && mdc_q && div_last;

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    div_d       = div_q;
    mdc_d       = mdc_q;
    write_d     = write_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    sr_d        = sr_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    load_drive  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          write_d    = req_write;
          cmd_d      = {2'b01, (req_write ? 2'b01 : 2'b10), req_phy, req_reg};
          wdata_d    = req_wdata;
          state_d    = nopre ? S_CMD : S_PRE;
          bit_d      = 6'd0;
          div_d      = 8'd0;
          mdc_d      = 1'b0;
          load_drive = 1'b1;
        end
      end
      default: begin
        div_d = div_last ? 8'd0 : div_q + 8'd1;
        if (div_last) mdc_d = !mdc_q;
        // Read data from the PHY is taken at the MDC rise of the bit after it.
        if (rise && !write_q) begin
          if (state_q == S_DATA && bit_q == 6'd0) err_d = sync2_q;
          else if (state_q == S_DATA || state_q == S_GAP) sr_d = {sr_q[14:0], sync2_q};
        end
        if (bit_end) begin
          load_drive = 1'b1;
          if (bit_q == last_bit(state_q)) begin
            bit_d = 6'd0;
            case (state_q)
              S_PRE:  state_d = S_CMD;
              S_CMD:  state_d = S_TA;
              S_TA:   state_d = S_DATA;
              S_DATA: state_d = S_GAP;
              default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rdata_d     = write_q ? 16'h0000 : sr_q;
                rsp_err_d   = write_q ? 1'b0 : err_q;
              end
            endcase
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
    endcase
    drive_d = load_drive ? drive_bit(state_d, bit_d, write_d, cmd_d, wdata_d)
                         : {oe_q, mdio_q};
    oe_d    = drive_d[1];
    mdio_d  = drive_d[0];
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      bit_q       <= 6'd0;
      div_q       <= 8'd0;
      mdc_q       <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      write_q     <= 1'b0;
      cmd_q       <= 14'd0;
      wdata_q     <= 16'd0;
      sr_q        <= 16'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'd0;
      rsp_err_q   <= 1'b0;
      ready_q     <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      mdc_q       <= mdc_d;
      mdio_q      <= mdio_d;
      oe_q        <= oe_d;
      write_q     <= write_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      sr_q        <= sr_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
      ready_q     <= ready_d;
      sync1_q     <= i_mdio;
      sync2_q     <= sync1_q;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign o_mdc     = mdc_q;
  assign o_mdio    = mdio_q;
  assign oe_mdio   = oe_q;

endmodule
